// File: rtl/sram_arbiter.sv
// sram_arbiter: multi-port req/ack arbiter and strobe sequencer for an
// asynchronous external SRAM. Each transaction runs IDLE -> SETUP ->
// ACCESS (ACCESS_CYCLES) -> HOLD. Every pin-facing output is a register.
module sram_arbiter #(
    parameter int NPORTS        = 3,
    parameter int AW            = 18,
    parameter int DW            = 8,
    parameter int ACCESS_CYCLES = 2,
    parameter int RR_MODE       = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NPORTS-1:0]    req,
    input  logic [NPORTS-1:0]    we,
    input  logic [NPORTS*AW-1:0] addr,
    input  logic [NPORTS*DW-1:0] wdata,
    output logic [NPORTS-1:0]    ack,
    output logic [DW-1:0]        rdata,
    output logic                 sram_cs_b,
    output logic                 sram_oe_b,
    output logic                 sram_we_b,
    output logic [AW-1:0]        sram_a,
    output logic [DW-1:0]        sram_dout,
    output logic                 sram_dout_en,
    input  logic [DW-1:0]        sram_din
);

    localparam int PW = $clog2(NPORTS);
    localparam int CW = $clog2(ACCESS_CYCLES) + 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

    state_t        state_reg;
    logic [CW-1:0] cnt_reg;
    logic [PW-1:0] last_reg;
    logic [PW-1:0] grant_reg;
    logic          op_we_reg;

    logic          grant_valid;
    logic [PW-1:0] grant_next;

    logic [AW-1:0] addr_arr  [NPORTS];
    logic [DW-1:0] wdata_arr [NPORTS];

    // Unpack the flat per-port operand buses into indexable arrays.
    generate
        for (genvar gi = 0; gi < NPORTS; gi++) begin : g_unpack
            assign addr_arr[gi]  = addr[gi*AW +: AW];
            assign wdata_arr[gi] = wdata[gi*DW +: DW];
        end
    endgenerate

    // Pick the winning port: lowest index, or first after the last winner.
    always_comb begin
        int            idx;
        logic [PW-1:0] idx_p;
        idx         = 0;
        idx_p       = '0;
        grant_valid = 1'b0;
        grant_next  = '0;
        if (RR_MODE != 0) begin
            for (int k = 1; k <= NPORTS; k++) begin
                idx = int'(last_reg) + k;
                if (idx >= NPORTS) begin
                    idx = idx - NPORTS;
                end
                idx_p = PW'(idx);
                if (!grant_valid && req[idx_p]) begin
                    grant_valid = 1'b1;
                    grant_next  = idx_p;
                end
            end
        end else begin
            for (int k = NPORTS - 1; k >= 0; k--) begin
                if (req[k]) begin
                    grant_valid = 1'b1;
                    grant_next  = PW'(k);
                end
            end
        end
    end

    // Transaction sequencer; reset aborts any access and releases the pins at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            sram_cs_b    <= 1'b1;
            sram_oe_b    <= 1'b1;
            sram_we_b    <= 1'b1;
            sram_dout_en <= 1'b0;
            ack          <= '0;
            rdata        <= '0;
            sram_a       <= '0;
            sram_dout    <= '0;
            cnt_reg      <= '0;
            last_reg     <= PW'(NPORTS - 1);
            grant_reg    <= '0;
            op_we_reg    <= 1'b0;
        end else begin
            ack <= '0;
            case (state_reg)
                IDLE: begin
                    sram_oe_b    <= 1'b1;
                    sram_we_b    <= 1'b1;
                    sram_dout_en <= 1'b0;
                    if (grant_valid) begin
                        grant_reg    <= grant_next;
                        op_we_reg    <= we[grant_next];
                        sram_a       <= addr_arr[grant_next];
                        sram_dout    <= wdata_arr[grant_next];
                        sram_dout_en <= we[grant_next];
                        sram_cs_b    <= 1'b0;
                        state_reg    <= SETUP;
                        if (RR_MODE != 0) begin
                            last_reg <= grant_next;
                        end
                    end else begin
                        sram_cs_b <= 1'b1;
                    end
                end
                SETUP: begin
                    // Address has had a full cycle to settle; open the strobe.
                    cnt_reg   <= CW'(ACCESS_CYCLES - 1);
                    sram_oe_b <= op_we_reg;
                    sram_we_b <= !op_we_reg;
                    state_reg <= ACCESS;
                end
                ACCESS: begin
                    if (cnt_reg == '0) begin
                        if (!op_we_reg) begin
                            rdata <= sram_din;
                        end
                        sram_oe_b <= 1'b1;
                        sram_we_b <= 1'b1;
                        ack       <= NPORTS'(1) << grant_reg;
                        state_reg <= HOLD;
                    end else begin
                        cnt_reg <= cnt_reg - CW'(1);
                    end
                end
                HOLD: begin
                    // Write data stayed driven through this cycle for hold time.
                    sram_dout_en <= 1'b0;
                    sram_cs_b    <= 1'b1;
                    state_reg    <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed bench for sram_arbiter. Four instances:
//   0: fixed priority, ACCESS_CYCLES=2   1: round-robin, ACCESS_CYCLES=2
//   2: round-robin,    ACCESS_CYCLES=1   3: fixed priority, ACCESS_CYCLES=4
// Each instance has its own behavioural SRAM and pin-rule monitor.
module tb_sram_arbiter;

    logic clk;
    logic reset;

    logic [3:0][2:0]  req;
    logic [3:0][2:0]  we;
    logic [3:0][53:0] addr;
    logic [3:0][23:0] wdata;
    logic [3:0][2:0]  ack;
    logic [3:0][7:0]  rdata;
    logic [3:0]       cs_b;
    logic [3:0]       oe_b;
    logic [3:0]       we_b;
    logic [3:0][17:0] sa;
    logic [3:0][7:0]  dout;
    logic [3:0]       dout_en;
    logic [3:0][7:0]  din;

    int tests_run    = 0;
    int tests_failed = 0;

    int ack_log[$];
    int ack_at[$];

    int fp_exp[5] = '{1, 1, 1, 2, 4};
    int rr_exp[6] = '{1, 2, 4, 1, 2, 4};

    localparam int NV = 8;
    logic        v_we   [NV] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    int          v_port [NV] = '{0, 1, 2, 2, 0, 1, 1, 0};
    logic [17:0] v_addr [NV] = '{18'h00000, 18'h3FFFF, 18'h00000, 18'h12345,
                                 18'h3FFFF, 18'h12345, 18'h00000, 18'h00000};
    logic [7:0]  v_data [NV] = '{8'h01, 8'hFE, 8'h01, 8'hA5, 8'hFE, 8'hA5, 8'h7E, 8'h7E};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_dut
            localparam int AC = (gi == 2) ? 1 : ((gi == 3) ? 4 : 2);
            localparam int RR = (gi == 1 || gi == 2) ? 1 : 0;

            logic [7:0]  mem [1024];
            int          viol        = 0;
            logic        prev_cs_low = 1'b0;
            logic [17:0] prev_a      = '0;

            sram_arbiter #(
                .NPORTS(3), .AW(18), .DW(8), .ACCESS_CYCLES(AC), .RR_MODE(RR)
            ) u_dut (
                .clk(clk),
                .reset(reset),
                .req(req[gi]),
                .we(we[gi]),
                .addr(addr[gi]),
                .wdata(wdata[gi]),
                .ack(ack[gi]),
                .rdata(rdata[gi]),
                .sram_cs_b(cs_b[gi]),
                .sram_oe_b(oe_b[gi]),
                .sram_we_b(we_b[gi]),
                .sram_a(sa[gi]),
                .sram_dout(dout[gi]),
                .sram_dout_en(dout_en[gi]),
                .sram_din(din[gi])
            );

            // Asynchronous SRAM: combinational read while selected and output-enabled.
            assign din[gi] = (!cs_b[gi] && !oe_b[gi]) ? mem[sa[gi][9:0]] : 8'h00;

            // Write lands while chip select and write enable are both low.
            always @(posedge clk) begin
                if (!cs_b[gi] && !we_b[gi]) begin
                    mem[sa[gi][9:0]] <= dout[gi];
                end
            end

            // Pin rules: strobes exclusive, no drive while OE low, address steady while selected.
            always @(negedge clk) begin
                if (reset) begin
                    prev_cs_low <= 1'b0;
                end else begin
                    viol <= viol + int'(!oe_b[gi] && !we_b[gi])
                                 + int'(dout_en[gi] && !oe_b[gi])
                                 + int'(prev_cs_low && !cs_b[gi] && (sa[gi] != prev_a));
                    prev_cs_low <= !cs_b[gi];
                    prev_a      <= sa[gi];
                end
            end
        end
    endgenerate

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_op(input int k, input int p, input logic w,
                          input logic [17:0] a, input logic [7:0] d);
        we[k][p]             = w;
        addr[k][p*18 +: 18]  = a;
        wdata[k][p*8 +: 8]   = d;
    endtask

    // One complete transaction on port p of instance k, starting from an IDLE cycle.
    task automatic txn(input int k, input int p, input logic w, input logic [17:0] a,
                       input logic [7:0] d, output logic [7:0] rd, output int lat, output int wl);
        @(negedge clk);
        set_op(k, p, w, a, d);
        req[k][p] = 1'b1;
        lat = 0;
        wl  = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!we_b[k]) wl++;
        end while (!ack[k][p] && lat < 40);
        rd = rdata[k];
        req[k][p] = 1'b0;
        $display("[TB] dut%0d port%0d %s addr=0x%05h data=0x%02h rdata=0x%02h latency=%0d",
                 k, p, w ? "wr" : "rd", a, d, rd, lat);
    endtask

    // Watch acks on instance k until n arrive; past drop_after acks the acked port lets go.
    task automatic collect(input int k, input int n, input int drop_after);
        int cyc;
        cyc = 0;
        ack_log.delete();
        ack_at.delete();
        while (ack_log.size() < n && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (ack[k] != 3'b000) begin
                ack_log.push_back(int'(ack[k]));
                ack_at.push_back(cyc);
                $display("[TB] dut%0d ack=%03b cycle=%0d", k, ack[k], cyc);
                if (ack_log.size() > drop_after) req[k] = req[k] & ~ack[k];
            end
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd;
        int         lat;
        int         wl;
        int         n;
        int         cnt;

        reset = 1'b1;
        req   = '0;
        we    = '0;
        addr  = '0;
        wdata = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state of every instance
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rst_strobes%0d", k), {cs_b[k], oe_b[k], we_b[k], dout_en[k]}, 4'b1110);
            check($sformatf("rst_ack%0d", k), ack[k], 3'b000);
            check($sformatf("rst_rdata%0d", k), rdata[k], 8'h00);
            check($sformatf("rst_addr%0d", k), sa[k], 18'h00000);
            check($sformatf("rst_dout%0d", k), dout[k], 8'h00);
        end

        // Single write then read on port 1
        txn(0, 1, 1'b1, 18'h003A5, 8'hC3, rd, lat, wl);
        check("wr_latency", lat, 4);
        check("wr_we_low_cycles", wl, 2);
        txn(0, 1, 1'b0, 18'h003A5, 8'h00, rd, lat, wl);
        check("rd_latency", lat, 4);
        check("rd_data", rd, 8'hC3);
        check("rd_we_low_cycles", wl, 0);

        // Fixed priority: all three request, port 0 lets go after three grants
        @(negedge clk);
        set_op(0, 0, 1'b0, 18'h003A5, 8'h00);
        set_op(0, 1, 1'b1, 18'h00100, 8'h11);
        set_op(0, 2, 1'b1, 18'h00101, 8'h22);
        req[0] = 3'b111;
        collect(0, 5, 2);
        req[0] = 3'b000;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("fp_ack%0d", i), (i < ack_log.size()) ? ack_log[i] : -1, fp_exp[i]);
        end

        // Round-robin: all three request continuously
        @(negedge clk);
        set_op(1, 0, 1'b1, 18'h00001, 8'hA0);
        set_op(1, 1, 1'b1, 18'h00002, 8'hA1);
        set_op(1, 2, 1'b1, 18'h00003, 8'hA2);
        req[1] = 3'b111;
        collect(1, 6, 6);
        req[1] = 3'b000;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("rr_ack%0d", i), (i < ack_log.size()) ? ack_log[i] : -1, rr_exp[i]);
        end
        check("rr_first_latency", (ack_at.size() > 0) ? ack_at[0] : -1, 4);
        for (int i = 1; i < 6; i++) begin
            check($sformatf("rr_gap%0d", i),
                  (i < ack_at.size()) ? ack_at[i] - ack_at[i-1] : -1, 5);
        end

        // Back-to-back on port 2: req held across ack with new operands
        @(negedge clk);
        set_op(0, 2, 1'b0, 18'h003A5, 8'h00);
        req[0][2] = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (ack[0] == 3'b000 && n < 40);
        $display("[TB] dut0 port2 rd addr=0x003a5 rdata=0x%02h latency=%0d", rdata[0], n);
        check("b2b_first_ack", ack[0], 3'b100);
        check("b2b_first_rdata", rdata[0], 8'hC3);
        set_op(0, 2, 1'b1, 18'h00010, 8'h5A);
        n = 0;
        do begin @(negedge clk); n++; end while (ack[0] == 3'b000 && n < 40);
        $display("[TB] dut0 port2 wr addr=0x00010 data=0x5a gap=%0d", n);
        check("b2b_second_ack", ack[0], 3'b100);
        check("b2b_gap", n, 5);
        req[0][2] = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ack[0] != 3'b000) cnt++;
        end
        check("b2b_no_extra_ack", cnt, 0);
        txn(0, 0, 1'b0, 18'h00010, 8'h00, rd, lat, wl);
        check("b2b_readback", rd, 8'h5A);

        // Mixed reads and writes at ACCESS_CYCLES = 1 and 4
        for (int k = 2; k < 4; k++) begin
            for (int i = 0; i < NV; i++) begin
                txn(k, v_port[i], v_we[i], v_addr[i], v_data[i], rd, lat, wl);
                check($sformatf("mix%0d_lat%0d", k, i), lat, (k == 2) ? 3 : 6);
                if (!v_we[i]) check($sformatf("mix%0d_rd%0d", k, i), rd, v_data[i]);
                else          check($sformatf("mix%0d_wl%0d", k, i), wl, (k == 2) ? 1 : 4);
            end
        end

        // Reset during the ACCESS phase of a write
        @(negedge clk);
        set_op(0, 1, 1'b1, 18'h00200, 8'h99);
        req[0][1] = 1'b1;
        repeat (2) @(negedge clk);
        check("pre_rst_we_b", we_b[0], 1'b0);
        check("pre_rst_dout_en", dout_en[0], 1'b1);
        #2 reset = 1'b1;
        #1;
        $display("[TB] dut0 port1 wr addr=0x00200 aborted by reset");
        check("rst_mid_we_b", we_b[0], 1'b1);
        check("rst_mid_dout_en", dout_en[0], 1'b0);
        check("rst_mid_cs_b", cs_b[0], 1'b1);
        req[0][1] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ack[0] != 3'b000) cnt++;
        end
        check("rst_mid_no_ack", cnt, 0);
        txn(0, 1, 1'b0, 18'h003A5, 8'h00, rd, lat, wl);
        check("post_rst_latency", lat, 4);
        check("post_rst_rdata", rd, 8'hC3);

        // Pin-rule violations seen by the monitors over the whole run
        check("viol_dut0", g_dut[0].viol, 0);
        check("viol_dut1", g_dut[1].viol, 0);
        check("viol_dut2", g_dut[2].viol, 0);
        check("viol_dut3", g_dut[3].viol, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Parametrised multi-port arbiter and timing sequencer for the asynchronous external SRAM.
- Replaces the ad-hoc video/CPU address mux and the clock-gated write-enable with a proper per-port req/ack handshake and programmable strobe width.
- Sits between the requesters (video fetch, CPU, bootstrap loader, future ports) and the SRAM pins.
- Supports fixed-priority or round-robin arbitration.

Parameters:
- NPORTS, 3, number of requester ports (2..8).
- AW, 18, SRAM address width.
- DW, 8, SRAM data width.
- ACCESS_CYCLES, 2, clk cycles that OE_b or WE_b is held low (≥1).
- RR_MODE, 0, 0 = fixed priority (port 0 highest), 1 = round-robin.

Ports:
- clk  in  1  single system clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  NPORTS  per-port request; held with its operands until ack.
- we  in  NPORTS  per-port write flag (1 = write).
- addr  in  NPORTS*AW  per-port address, port i at [i*AW +: AW].
- wdata  in  NPORTS*DW  per-port write data, port i at [i*DW +: DW].
- ack  out  NPORTS  one-cycle completion pulse, one-hot or zero.
- rdata  out  DW  registered read data, valid in the ack cycle of a read.
- sram_cs_b  out  1  chip select, active low.
- sram_oe_b  out  1  output enable, active low.
- sram_we_b  out  1  write enable, active low.
- sram_a  out  AW  SRAM address.
- sram_dout  out  DW  data to the pins.
- sram_dout_en  out  1  pin output-enable for sram_dout.
- sram_din  in  DW  data from the pins.

Behaviour:
- Reset values:
  - state = IDLE; cs_b, oe_b, we_b = 1.
  - dout_en = 0; ack = 0; rdata = 0; sram_a = 0; sram_dout = 0.
  - Round-robin pointer last = NPORTS-1, so port 0 is favoured first.
- All outputs are registered.
- FSM states are IDLE, SETUP, ACCESS and HOLD.
- IDLE:
  - If no req, remain in IDLE with all strobes inactive.
  - Otherwise choose the winner g:
    - RR_MODE=0: lowest-index asserted req.
    - RR_MODE=1: first asserted req scanning last+1, last+2, … modulo NPORTS.
  - Latch addr[g], we[g] and wdata[g]. Drive sram_a and sram_dout, set cs_b = 0, and go to SETUP.
  - In RR mode, last ← g.
- SETUP (1 cycle): address stable, oe_b = we_b = 1. dout_en = 1 if write. Load cnt = ACCESS_CYCLES-1 and go to ACCESS.
- ACCESS (ACCESS_CYCLES cycles):
  - Read: oe_b = 0.
  - Write: we_b = 0, dout_en = 1.
  - cnt decrements each cycle.
  - On the final cycle (cnt == 0), a read samples sram_din into rdata. Then go to HOLD.
- HOLD (1 cycle):
  - oe_b = we_b = 1, while address and cs_b are held.
  - dout_en stays 1 for a write (data hold after WE rising), then drops.
  - ack[g] = 1. rdata holds the read value (unchanged for writes).
  - Next state is IDLE. cs_b returns to 1 in IDLE unless a new grant occurs in the same cycle.
- Timing:
  - Transaction period is ACCESS_CYCLES + 3 cycles, IDLE through HOLD.
  - Request-to-ack latency is ACCESS_CYCLES + 2 cycles from the IDLE cycle in which req is sampled.
- Handshake:
  - The requester keeps req and operands stable until it sees ack.
  - It may keep req high in the cycle after ack to issue a new transaction with new operands; that request is arbitrated in the following IDLE.
  - Dropping req before ack is illegal; the latched operands are still used and ack is still issued.
- Mutual exclusion: oe_b and we_b are never 0 simultaneously; dout_en is never 1 while oe_b = 0.
- Simultaneous requests:
  - Fixed mode: port 0 can starve the others. This is intended for video.
  - RR mode: each continuously requesting port is granted at least once every NPORTS transactions.
- Reset mid-transaction: the in-flight transaction is aborted with no ack. All strobes go inactive immediately (asynchronously) and the FSM returns to IDLE.
- Arithmetic: cnt width is clog2(ACCESS_CYCLES)+1. The RR pointer wraps modulo NPORTS, including non-power-of-two values.

Test Plan:
- Single write then read: port 1 writes 0x3A5 ← 0xC3, then reads 0x3A5 with a model SRAM.
  - ack[1] arrives ACCESS_CYCLES+2 cycles after each IDLE sample.
  - rdata = 0xC3 in the read's ack cycle.
  - we_b is low for exactly 2 cycles.
- Fixed priority: ports 0, 1 and 2 request simultaneously and continuously with RR_MODE=0.
  - Only port 0 is acked.
  - After port 0 drops req, port 1 is acked, then port 2.
- Round-robin: all three ports request continuously with RR_MODE=1.
  - Ack order is 0, 1, 2, 0, 1, 2.
  - Each ack is spaced 5 cycles apart.
- Strobe integrity: random reads and writes with ACCESS_CYCLES=1 and 4.
  - Assertions: oe_b and we_b are never both low.
  - Assertions: dout_en is 0 whenever oe_b = 0.
  - Assertions: sram_a is stable from SETUP through HOLD.
- Back-to-back: port 2 holds req after ack with new addr 0x00010.
  - The second transaction starts in the next IDLE.
  - No ack is duplicated or lost.
- Reset mid-operation: assert reset during ACCESS of a write.
  - we_b = 1 and dout_en = 0 immediately.
  - No ack is issued.
  - After release, a fresh request completes normally.
